// File: rtl/pinmux_pkg.sv
// Shared constants for the pin multiplexer: register map bases, default
// sizing and the select-field width helpers.
package pinmux_pkg;

  localparam int DefNPads        = 64;
  localparam int DefNPeriphIn    = 24;
  localparam int DefNPeriphOut   = 24;
  localparam int DefFilterCycles = 4;

  localparam logic [9:0] OutSelBase = 10'h000;
  localparam logic [9:0] InSelBase  = 10'h100;
  localparam logic [9:0] FiltEnBase = 10'h200;
  localparam logic [9:0] LockAddr   = 10'h3FF;

  // FilterCycles is capped at 255, so an 8-bit counter always suffices.
  localparam int FiltCntW = 8;

  function automatic int out_sel_width(input int n_periph_out);
    return $clog2(n_periph_out + 1);
  endfunction

  function automatic int in_sel_width(input int n_pads);
    return $clog2(n_pads + 2);
  endfunction

endpackage

// File: rtl/pinmux_ctrl_if.sv
// Register access bus of the pin multiplexer; the host side is the master.
interface pinmux_ctrl_if;

  logic        reg_we_i;
  logic        reg_re_i;
  logic [9:0]  reg_addr_i;
  logic [31:0] reg_wdata_i;
  logic [31:0] reg_rdata_o;
  logic        reg_err_o;

  modport master (
    output reg_we_i, reg_re_i, reg_addr_i, reg_wdata_i,
    input  reg_rdata_o, reg_err_o
  );

  modport slave (
    input  reg_we_i, reg_re_i, reg_addr_i, reg_wdata_i,
    output reg_rdata_o, reg_err_o
  );

endinterface

// File: rtl/pinmux_pad_filter.sv
// Per-pad input conditioning: 2-flop synchroniser, plus an optional glitch
// filter when PINMUX_FILTER_EN is defined.
module pinmux_pad_filter
  import pinmux_pkg::*;
`ifdef PINMUX_FILTER_EN
#(
  parameter int FilterCycles = DefFilterCycles
)
`endif
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic pad_i,
`ifdef PINMUX_FILTER_EN
  input  logic filt_en_i,
  input  logic filt_load_i,
`endif
  output logic cond_o
);

  logic sync_q1;
  logic sync_q2;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= pad_i;
      sync_q2 <= sync_q1;
    end
  end

`ifdef PINMUX_FILTER_EN
  logic                flt_q;
  logic [FiltCntW-1:0] cnt_q;

  // A new level is adopted only after it has disagreed with the filtered
  // value for FilterCycles consecutive samples; any agreement restarts the run.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flt_q <= 1'b0;
      cnt_q <= '0;
    end else if (filt_load_i) begin
      flt_q <= sync_q2;
      cnt_q <= '0;
    end else if (sync_q2 == flt_q) begin
      cnt_q <= '0;
    end else if (cnt_q == FiltCntW'(FilterCycles - 1)) begin
      flt_q <= sync_q2;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cond_o = filt_en_i ? flt_q : sync_q2;
`else
  assign cond_o = sync_q2;
`endif

endmodule

// File: rtl/pinmux_ctrl.sv
// Pin multiplexer: register-programmed routing between pads and peripherals.
// Define PINMUX_FILTER_EN to build the per-pad glitch filter and filt_en block.
module pinmux_ctrl
  import pinmux_pkg::*;
#(
  parameter int NPads        = DefNPads,
  parameter int NPeriphIn    = DefNPeriphIn,
  parameter int NPeriphOut   = DefNPeriphOut,
  parameter int FilterCycles = DefFilterCycles
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NPads-1:0]      pad_in_i,
  output logic [NPads-1:0]      pad_out_o,
  output logic [NPads-1:0]      pad_oe_o,
  input  logic [NPeriphOut-1:0] periph_out_i,
  input  logic [NPeriphOut-1:0] periph_oe_i,
  output logic [NPeriphIn-1:0]  periph_in_o,
  pinmux_ctrl_if.slave          reg_bus
);

  localparam int OSW = out_sel_width(NPeriphOut);
  localparam int ISW = in_sel_width(NPads);

`ifdef PINMUX_FILTER_EN
  localparam bit FiltBuild = 1'b1;
`else
  localparam bit FiltBuild = 1'b0;
`endif

  if (FilterCycles < 2 || FilterCycles > 255) begin : g_bad_filter_cycles
    $error("pinmux_ctrl: FilterCycles must lie in 2..255");
  end

  logic [OSW-1:0]   out_sel [NPads];
  logic [ISW-1:0]   in_sel  [NPeriphIn];
  logic             lock_q;
  logic [NPads-1:0] pad_cond;

  logic [7:0]  idx;
  logic        is_out, is_in, is_filt, is_lock;
  logic        mapped, val_ok, wr_ok, wr_err;
  logic [31:0] rd_next;

  assign idx = reg_bus.reg_addr_i[7:0];

  // A write must hit a mapped register with an in-range value while unlocked;
  // every other write is dropped and flagged.
  always_comb begin
    is_lock = (reg_bus.reg_addr_i == LockAddr);
    is_out  = !is_lock && (reg_bus.reg_addr_i[9:8] == OutSelBase[9:8]) && (32'(idx) < 32'(NPads));
    is_in   = !is_lock && (reg_bus.reg_addr_i[9:8] == InSelBase[9:8])  && (32'(idx) < 32'(NPeriphIn));
    is_filt = !is_lock && (reg_bus.reg_addr_i[9:8] == FiltEnBase[9:8]) && (32'(idx) < 32'(NPads));
    mapped  = is_out | is_in | (is_filt & FiltBuild) | is_lock;
    val_ok  = 1'b1;
    if (is_out) begin
      val_ok = (reg_bus.reg_wdata_i <= 32'(NPeriphOut));
    end else if (is_in) begin
      val_ok = (reg_bus.reg_wdata_i <= 32'(NPads + 1));
    end else if (is_filt) begin
      val_ok = (reg_bus.reg_wdata_i <= 32'd1);
    end
    wr_ok  = reg_bus.reg_we_i && mapped && val_ok && !lock_q;
    wr_err = reg_bus.reg_we_i && !wr_ok;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int p = 0; p < NPads; p++) out_sel[p] <= '0;
      for (int j = 0; j < NPeriphIn; j++) in_sel[j] <= '0;
      lock_q <= 1'b0;
    end else if (wr_ok) begin
      for (int p = 0; p < NPads; p++) begin
        if (is_out && idx == 8'(p)) out_sel[p] <= reg_bus.reg_wdata_i[OSW-1:0];
      end
      for (int j = 0; j < NPeriphIn; j++) begin
        if (is_in && idx == 8'(j)) in_sel[j] <= reg_bus.reg_wdata_i[ISW-1:0];
      end
      if (is_lock && reg_bus.reg_wdata_i[0]) lock_q <= 1'b1;
    end
  end

`ifdef PINMUX_FILTER_EN
  logic [NPads-1:0] filt_en;
  logic [NPads-1:0] filt_load;

  always_comb begin
    filt_load = '0;
    for (int p = 0; p < NPads; p++) begin
      filt_load[p] = wr_ok && is_filt && (idx == 8'(p));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      filt_en <= '0;
    end else begin
      for (int p = 0; p < NPads; p++) begin
        if (filt_load[p]) filt_en[p] <= reg_bus.reg_wdata_i[0];
      end
    end
  end

  for (genvar p = 0; p < NPads; p++) begin : g_pad
    pinmux_pad_filter #(
      .FilterCycles(FilterCycles)
    ) u_pad_filter (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .pad_i      (pad_in_i[p]),
      .filt_en_i  (filt_en[p]),
      .filt_load_i(filt_load[p]),
      .cond_o     (pad_cond[p])
    );
  end
`else
  for (genvar p = 0; p < NPads; p++) begin : g_pad
    pinmux_pad_filter u_pad_filter (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .pad_i (pad_in_i[p]),
      .cond_o(pad_cond[p])
    );
  end
`endif

  // Reads sample the registers before any same-cycle write lands.
  always_comb begin
    rd_next = '0;
    if (reg_bus.reg_re_i) begin
      for (int p = 0; p < NPads; p++) begin
        if (is_out && idx == 8'(p)) rd_next = 32'(out_sel[p]);
      end
      for (int j = 0; j < NPeriphIn; j++) begin
        if (is_in && idx == 8'(j)) rd_next = 32'(in_sel[j]);
      end
`ifdef PINMUX_FILTER_EN
      for (int p = 0; p < NPads; p++) begin
        if (is_filt && idx == 8'(p)) rd_next = 32'(filt_en[p]);
      end
`endif
      if (is_lock) rd_next = {31'd0, lock_q};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      reg_bus.reg_rdata_o <= '0;
      reg_bus.reg_err_o   <= 1'b0;
    end else begin
      reg_bus.reg_rdata_o <= rd_next;
      reg_bus.reg_err_o   <= wr_err;
    end
  end

  always_comb begin
    pad_out_o = '0;
    pad_oe_o  = '0;
    for (int p = 0; p < NPads; p++) begin
      for (int k = 0; k < NPeriphOut; k++) begin
        if (out_sel[p] == OSW'(k + 1)) begin
          pad_out_o[p] = periph_out_i[k];
          pad_oe_o[p]  = periph_oe_i[k];
        end
      end
    end
  end

  // Select 0 and 1 are the constants; pads start at select 2.
  always_comb begin
    periph_in_o = '0;
    for (int j = 0; j < NPeriphIn; j++) begin
      if (in_sel[j] == ISW'(1)) periph_in_o[j] = 1'b1;
      for (int p = 0; p < NPads; p++) begin
        if (in_sel[j] == ISW'(p + 2)) periph_in_o[j] = pad_cond[p];
      end
    end
  end

endmodule

// File: tb/tb_pinmux_ctrl.sv
// Scoreboard bench for pinmux_ctrl; the filter scenario is built only when
// PINMUX_FILTER_EN is defined, otherwise the filt_en block is checked as unmapped.
module tb_pinmux_ctrl;
  import pinmux_pkg::*;

  localparam int NPads        = 64;
  localparam int NPeriphIn    = 24;
  localparam int NPeriphOut   = 24;
  localparam int FilterCycles = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NPads-1:0]      pad_in = '0;
  logic [NPads-1:0]      pad_out;
  logic [NPads-1:0]      pad_oe;
  logic [NPeriphOut-1:0] periph_out = '0;
  logic [NPeriphOut-1:0] periph_oe = '0;
  logic [NPeriphIn-1:0]  periph_in;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  pinmux_ctrl_if bus();

  always #5 clk = ~clk;

  pinmux_ctrl #(
    .NPads       (NPads),
    .NPeriphIn   (NPeriphIn),
    .NPeriphOut  (NPeriphOut),
    .FilterCycles(FilterCycles)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .pad_in_i    (pad_in),
    .pad_out_o   (pad_out),
    .pad_oe_o    (pad_oe),
    .periph_out_i(periph_out),
    .periph_oe_i (periph_oe),
    .periph_in_o (periph_in),
    .reg_bus     (bus)
  );

  // One register bus cycle; returns the registered response seen 1 ns after the edge.
  task automatic bus_cycle(input logic we, input logic re, input logic [9:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rd, output logic er);
    @(negedge clk);
    bus.reg_we_i    = we;
    bus.reg_re_i    = re;
    bus.reg_addr_i  = addr;
    bus.reg_wdata_i = wdata;
    @(posedge clk);
    #1;
    bus.reg_we_i = 1'b0;
    bus.reg_re_i = 1'b0;
    rd = bus.reg_rdata_o;
    er = bus.reg_err_o;
  endtask

  task automatic test_reset();
    pad_in     = {$urandom(), $urandom()};
    periph_out = '1;
    periph_oe  = '1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (pad_oe !== '0) begin errors++; $display("[TB] FAIL reset_oe: got %h want 0", pad_oe); end
    checks++;
    if (pad_out !== '0) begin errors++; $display("[TB] FAIL reset_out: got %h want 0", pad_out); end
    checks++;
    if (periph_in !== '0) begin errors++; $display("[TB] FAIL reset_periph_in: got %h want 0", periph_in); end
    checks++;
    if (bus.reg_rdata_o !== 32'd0 || bus.reg_err_o !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_bus: got rdata %h err %b want 0 0", bus.reg_rdata_o, bus.reg_err_o);
    end
    rst = 1'b0;
    pad_in = '0;
    periph_out = '0;
    periph_oe = '0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_out_route();
    logic [31:0] rd; logic er; exp_t e;
    exp_q.push_back('{32'd0, 1'b0});
    bus_cycle(1'b1, 1'b0, 10'h005, 32'd3, rd, er);
    e = exp_q.pop_front();
    checks++;
    if (rd !== e.rdata || er !== e.err) begin errors++; $display("[TB] FAIL wr_out_sel5: got %h/%b want %h/%b", rd, er, e.rdata, e.err); end
    periph_out = 24'h000004;
    periph_oe  = 24'h000004;
    #1;
    checks++;
    if (pad_out !== 64'h20 || pad_oe !== 64'h20) begin
      errors++; $display("[TB] FAIL out_route: got out %h oe %h want 20 20", pad_out, pad_oe);
    end
    periph_out[2] = 1'b0;
    #1;
    checks++;
    if (pad_out !== 64'h0 || pad_oe !== 64'h20) begin
      errors++; $display("[TB] FAIL out_comb: got out %h oe %h want 0 20", pad_out, pad_oe);
    end
    periph_out[2] = 1'b1;
    exp_q.push_back('{32'd0, 1'b0});
    bus_cycle(1'b1, 1'b0, 10'h009, 32'd3, rd, er);
    e = exp_q.pop_front();
    checks++;
    if (rd !== e.rdata || er !== e.err || pad_oe !== 64'h220 || pad_out !== 64'h220) begin
      errors++; $display("[TB] FAIL out_shared: got %h/%b oe %h want %h/%b oe 220", rd, er, pad_oe, e.rdata, e.err);
    end
    exp_q.push_back('{32'd3, 1'b0});
    bus_cycle(1'b0, 1'b1, 10'h005, 32'd0, rd, er);
    e = exp_q.pop_front();
    checks++;
    if (rd !== e.rdata || er !== e.err) begin errors++; $display("[TB] FAIL rd_out_sel5: got %h/%b want %h/%b", rd, er, e.rdata, e.err); end
  endtask

  task automatic test_in_route();
    logic [31:0] rd; logic er; exp_t e;
    logic [9:0]  addrs [3];
    logic [31:0] vals  [3];
    addrs = '{10'h100, 10'h101, 10'h102};
    vals  = '{32'd9, 32'd1, 32'd9};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{32'd0, 1'b0});
      bus_cycle(1'b1, 1'b0, addrs[i], vals[i], rd, er);
      e = exp_q.pop_front();
      checks++;
      if (rd !== e.rdata || er !== e.err) begin errors++; $display("[TB] FAIL wr_in_sel%0d: got %h/%b want %h/%b", i, rd, er, e.rdata, e.err); end
    end
    checks++;
    if (periph_in !== 24'h000002) begin errors++; $display("[TB] FAIL in_const: got %h want 000002", periph_in); end
    pad_in[7] = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (periph_in !== 24'h000002) begin errors++; $display("[TB] FAIL in_lat1: got %h want 000002", periph_in); end
    @(posedge clk); #1;
    checks++;
    if (periph_in !== 24'h000007) begin errors++; $display("[TB] FAIL in_lat2: got %h want 000007", periph_in); end
  endtask

`ifdef PINMUX_FILTER_EN
  task automatic test_filter();
    logic [31:0] rd; logic er; exp_t e; logic want;
    pad_in[7] = 1'b0;
    repeat (3) @(posedge clk);
    exp_q.push_back('{32'd0, 1'b0});
    bus_cycle(1'b1, 1'b0, 10'h207, 32'd1, rd, er);
    e = exp_q.pop_front();
    checks++;
    if (rd !== e.rdata || er !== e.err) begin errors++; $display("[TB] FAIL wr_filt_en7: got %h/%b want %h/%b", rd, er, e.rdata, e.err); end
    exp_q.push_back('{32'd1, 1'b0});
    bus_cycle(1'b0, 1'b1, 10'h207, 32'd0, rd, er);
    e = exp_q.pop_front();
    checks++;
    if (rd !== e.rdata || er !== e.err) begin errors++; $display("[TB] FAIL rd_filt_en7: got %h/%b want %h/%b", rd, er, e.rdata, e.err); end
    pad_in[7] = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk); #1;
      if (c == 3) pad_in[7] = 1'b0;
      checks++;
      if (periph_in[0] !== 1'b0) begin errors++; $display("[TB] FAIL filt_glitch c%0d: got %b want 0", c, periph_in[0]); end
    end
    pad_in[7] = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      want = (c >= 2 + FilterCycles);
      checks++;
      if (periph_in[0] !== want) begin errors++; $display("[TB] FAIL filt_rise c%0d: got %b want %b", c, periph_in[0], want); end
    end
  endtask
`else
  task automatic test_filter();
    logic [31:0] rd; logic er; exp_t e;
    exp_q.push_back('{32'd0, 1'b1});
    bus_cycle(1'b1, 1'b0, 10'h207, 32'd1, rd, er);
    e = exp_q.pop_front();
    checks++;
    if (rd !== e.rdata || er !== e.err) begin errors++; $display("[TB] FAIL filt_unmapped_wr: got %h/%b want %h/%b", rd, er, e.rdata, e.err); end
    exp_q.push_back('{32'd0, 1'b0});
    bus_cycle(1'b0, 1'b1, 10'h207, 32'd0, rd, er);
    e = exp_q.pop_front();
    checks++;
    if (rd !== e.rdata || er !== e.err) begin errors++; $display("[TB] FAIL filt_unmapped_rd: got %h/%b want %h/%b", rd, er, e.rdata, e.err); end
  endtask
`endif

  task automatic test_out_of_range();
    logic [31:0] rd; logic er; exp_t e;
    logic        we_t [12];
    logic [9:0]  ad_t [12];
    logic [31:0] wd_t [12];
    logic [31:0] er_d [12];
    logic        er_e [12];
    we_t = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    ad_t = '{10'h000, 10'h000, 10'h001, 10'h001, 10'h100, 10'h100,
             10'h118, 10'h118, 10'h040, 10'h3FE, 10'h300, 10'h101};
    wd_t = '{32'd25, 32'd0, 32'd24, 32'd0, 32'd66, 32'd0, 32'd1, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0};
    er_d = '{32'd0, 32'd0, 32'd0, 32'd24, 32'd0, 32'd9, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1};
    er_e = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back('{er_d[i], er_e[i]});
      bus_cycle(we_t[i], !we_t[i], ad_t[i], wd_t[i], rd, er);
      e = exp_q.pop_front();
      checks++;
      if (rd !== e.rdata || er !== e.err) begin
        errors++; $display("[TB] FAIL range_%0d addr %h: got %h/%b want %h/%b", i, ad_t[i], rd, er, e.rdata, e.err);
      end
    end
  endtask

  task automatic test_rw_same();
    logic [31:0] rd; logic er; exp_t e;
    exp_q.push_back('{32'd3, 1'b0});
    bus_cycle(1'b1, 1'b1, 10'h005, 32'd7, rd, er);
    e = exp_q.pop_front();
    checks++;
    if (rd !== e.rdata || er !== e.err) begin errors++; $display("[TB] FAIL rw_same_old: got %h/%b want %h/%b", rd, er, e.rdata, e.err); end
    checks++;
    if (pad_oe !== 64'h200) begin errors++; $display("[TB] FAIL rw_same_oe: got %h want 200", pad_oe); end
    exp_q.push_back('{32'd7, 1'b0});
    bus_cycle(1'b0, 1'b1, 10'h005, 32'd0, rd, er);
    e = exp_q.pop_front();
    checks++;
    if (rd !== e.rdata || er !== e.err) begin errors++; $display("[TB] FAIL rw_same_new: got %h/%b want %h/%b", rd, er, e.rdata, e.err); end
  endtask

  task automatic test_lock();
    logic [31:0] rd; logic er; exp_t e;
    logic        we_t [6];
    logic [9:0]  ad_t [6];
    logic [31:0] wd_t [6];
    we_t = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    ad_t = '{10'h3FF, 10'h000, 10'h000, 10'h3FF, 10'h3FF, 10'h3FF};
    wd_t = '{32'd1, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0};
    exp_q.push_back('{32'd0, 1'b0});
    exp_q.push_back('{32'd0, 1'b1});
    exp_q.push_back('{32'd0, 1'b0});
    exp_q.push_back('{32'd1, 1'b0});
    exp_q.push_back('{32'd0, 1'b1});
    exp_q.push_back('{32'd1, 1'b0});
    for (int i = 0; i < 6; i++) begin
      bus_cycle(we_t[i], !we_t[i], ad_t[i], wd_t[i], rd, er);
      e = exp_q.pop_front();
      checks++;
      if (rd !== e.rdata || er !== e.err) begin
        errors++; $display("[TB] FAIL lock_%0d addr %h: got %h/%b want %h/%b", i, ad_t[i], rd, er, e.rdata, e.err);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; exp_t e;
    periph_out = '1;
    periph_oe  = '1;
    #1;
    checks++;
    if (pad_oe !== 64'h222) begin errors++; $display("[TB] FAIL pre_reset_oe: got %h want 222", pad_oe); end
    pad_in[7] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus.reg_we_i    = 1'b1;
    bus.reg_re_i    = 1'b1;
    bus.reg_addr_i  = 10'h002;
    bus.reg_wdata_i = 32'd2;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.reg_we_i = 1'b0;
    bus.reg_re_i = 1'b0;
    checks++;
    if (pad_oe !== '0 || pad_out !== '0) begin errors++; $display("[TB] FAIL mid_reset_pads: got out %h oe %h want 0 0", pad_out, pad_oe); end
    checks++;
    if (periph_in !== '0) begin errors++; $display("[TB] FAIL mid_reset_periph_in: got %h want 0", periph_in); end
    checks++;
    if (bus.reg_rdata_o !== 32'd0 || bus.reg_err_o !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_reset_bus: got %h/%b want 0/0", bus.reg_rdata_o, bus.reg_err_o);
    end
    exp_q.push_back('{32'd0, 1'b0});
    bus_cycle(1'b0, 1'b1, 10'h3FF, 32'd0, rd, er);
    e = exp_q.pop_front();
    checks++;
    if (rd !== e.rdata || er !== e.err) begin errors++; $display("[TB] FAIL mid_reset_lock: got %h/%b want %h/%b", rd, er, e.rdata, e.err); end
    exp_q.push_back('{32'd0, 1'b0});
    bus_cycle(1'b1, 1'b0, 10'h000, 32'd1, rd, er);
    e = exp_q.pop_front();
    checks++;
    if (rd !== e.rdata || er !== e.err || pad_out !== 64'h1 || pad_oe !== 64'h1) begin
      errors++; $display("[TB] FAIL post_reset_write: got %h/%b out %h want %h/%b out 1", rd, er, pad_out, e.rdata, e.err);
    end
`ifdef PINMUX_FILTER_EN
    exp_q.push_back('{32'd0, 1'b0});
    bus_cycle(1'b0, 1'b1, 10'h207, 32'd0, rd, er);
    e = exp_q.pop_front();
    checks++;
    if (rd !== e.rdata || er !== e.err) begin errors++; $display("[TB] FAIL mid_reset_filt_en: got %h/%b want %h/%b", rd, er, e.rdata, e.err); end
`endif
  endtask

  initial begin
    bus.reg_we_i    = 1'b0;
    bus.reg_re_i    = 1'b0;
    bus.reg_addr_i  = '0;
    bus.reg_wdata_i = '0;
    $display("[TB] pinmux_ctrl bench start");
    test_reset();
    test_out_route();
    test_in_route();
    test_filter();
    test_out_of_range();
    test_rw_same();
    test_lock();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pinmux_ctrl.md
PINMUX_CTRL -- requirements
Module: pinmux_ctrl

Interface
REQ-001 SHALL have parameter NPads, default 64, number of pads.
REQ-002 SHALL have parameter NPeriphIn, default 24, number of peripheral input signals.
REQ-003 SHALL have parameter NPeriphOut, default 24, number of peripheral output/enable pairs.
REQ-004 SHALL have parameter FilterCycles, default 4, range 2..255, glitch-filter stability length in cycles.
REQ-005 SHALL have port clk_i, input, 1, the single clock; all state on rising edge.
REQ-006 SHALL have port rst_i, input, 1, reset, synchronous and active-high.
REQ-007 SHALL have port pad_in_i, input, NPads, raw pad input values, asynchronous to clk_i.
REQ-008 SHALL have ports pad_out_o and pad_oe_o, output, NPads each, pad drive value and output enable.
REQ-009 SHALL have ports periph_out_i and periph_oe_i, input, NPeriphOut each, peripheral drive and enable.
REQ-010 SHALL have port periph_in_o, output, NPeriphIn, routed inputs to peripherals.
REQ-011 SHALL have register ports reg_we_i (1), reg_re_i (1), reg_addr_i (10), reg_wdata_i (32), reg_rdata_o (32), reg_err_o (1).

Function
REQ-012 SHALL decode word addresses: 0x000+p out_sel[p]; 0x100+j in_sel[j]; 0x200+p filt_en[p]; 0x3FF lock.
REQ-013 SHALL treat out_sel value 0 as disabled (pad_out 0, pad_oe 0), and value k in 1..NPeriphOut as routing periph_out_i[k-1] and periph_oe_i[k-1].
REQ-014 SHALL treat in_sel value 0 as constant 0, value 1 as constant 1, and value 2+p as routing the conditioned pad p.
REQ-015 SHALL make the output path combinational from the registers, with zero cycles from periph_out_i to pad_out_o.
REQ-016 SHALL pass each pad input through a 2-flop synchroniser, so periph_in_o follows pad_in_i 2 cycles later when filtering is off.
REQ-017 SHALL, with filt_en[p]=1, hold a per-pad filtered value plus a counter.
REQ-018 SHALL reset that counter to 0 whenever the synchronised value equals the filtered value.
REQ-019 SHALL otherwise increment that counter; on the cycle it equals FilterCycles-1, the filtered value takes the synchronised value and the counter clears.
REQ-020 SHALL therefore give a filtered latency of 2+FilterCycles cycles, and suppress pulses shorter than FilterCycles cycles.
REQ-021 SHALL, on a filt_en write, clear the counter and load the filtered value with the current synchronised value.
REQ-022 SHALL complete a write in one cycle, taking effect on outputs the cycle after reg_we_i.
REQ-023 SHALL present reg_rdata_o registered, 1 cycle after reg_re_i, and 0 on other cycles; unmapped addresses read 0.
REQ-024 SHALL reject, with no state change and a 1-cycle reg_err_o pulse, any write that is out of range, any write to an unmapped address, or any write while lock=1.
REQ-025 SHALL make lock sticky once bit0 is written 1, clearable only by rst_i, with the locking write itself accepted.
REQ-026 SHALL, if reg_we_i and reg_re_i are asserted together on the same address, return the pre-write value.
REQ-027 SHALL allow several pads to select the same peripheral output, and several peripheral inputs to select the same pad.

Reset
REQ-028 SHALL, on rst_i high at a clock edge, clear all out_sel, in_sel, filt_en, lock, synchroniser flops, filtered values, counters, reg_rdata_o and reg_err_o to 0.
REQ-029 SHALL thereby drive pad_oe_o=0, pad_out_o=0 and periph_in_o=0 from the first cycle after reset.
REQ-030 SHALL let rst_i override any concurrent register access or filter activity.

Configuration
REQ-031 SHALL, with PINMUX_FILTER_EN defined, implement the glitch filter and the filt_en registers.
REQ-032 SHALL, without PINMUX_FILTER_EN, omit the filter logic, make 0x200 block addresses unmapped (read 0, write error), and use synchroniser-only 2-cycle input latency.

Structure
REQ-033 SHALL place the address base constants, lock address, and out_sel/in_sel width localparams in a shared package pinmux_pkg.
REQ-034 SHALL size out_sel as $clog2(NPeriphOut+1) and in_sel as $clog2(NPads+2).
REQ-035 SHALL use one sub-module, pinmux_pad_filter (synchroniser plus filter per pad), instantiated NPads times.

Verification
REQ-036 SHALL cover: write out_sel[5]=3, drive periph_out_i[2]=1 and periph_oe_i[2]=1 -> pad_out_o[5]=1 and pad_oe_o[5]=1 the next cycle; all other pads have oe=0.
REQ-037 SHALL cover: in_sel[0]=2+7, filt_en[7]=0, pad_in_i[7] 0->1 -> periph_in_o[0]=1 exactly 2 cycles later.
REQ-038 SHALL cover: FilterCycles=4, filt_en[7]=1, a 3-cycle high pulse on pad 7 -> no change on periph_in_o; a 4-cycle-stable high -> rises at cycle 6.
REQ-039 SHALL cover: write lock=1, then write out_sel[0]=1 -> reg_err_o pulses, readback of 0x000 returns 0, lock reads 1.
REQ-040 SHALL cover: write out_sel[0]=NPeriphOut+1 -> reg_err_o pulses and the value is unchanged.
REQ-041 SHALL cover: rst_i mid-filter-count with outputs configured -> all outputs 0 the next cycle and lock=0.
